// File: rtl/synth_pkg.sv
// Shared definitions for the oscillator phase path.
//   PHASE_WIDTH / CHUNK_WIDTH / NUM_VOICES : default geometry of the accumulator
//   voice_idx_t : voice index at the default voice count
//   stage_t     : pipeline-stage layout at the default geometry
package synth_pkg;

    localparam int unsigned PHASE_WIDTH = 32;
    localparam int unsigned CHUNK_WIDTH = 8;
    localparam int unsigned NUM_VOICES  = 8;
    localparam int unsigned VOICE_BITS  = $clog2(NUM_VOICES);

    typedef logic [VOICE_BITS-1:0] voice_idx_t;

    typedef struct packed {
        logic                     valid;
        logic                     kill;
        voice_idx_t               voice;
        logic [PHASE_WIDTH-1:0]   acc;
        logic [2*PHASE_WIDTH-1:0] opnd_hi;
        logic                     carry;
    } stage_t;

endpackage

// File: rtl/chunk_adder_stage.sv
// One registered slice of the carry-pipelined phase adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b, c_in : operand chunks and carry from the previous slice
//   sum, c_out : registered chunk sum and carry to the next slice
module chunk_adder_stage #(
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {c_out, sum} <= '0;
        end else begin
            {c_out, sum} <= {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
        end
    end

endmodule

// File: rtl/pipelined_phase_accumulator.sv
// Time-multiplexed multi-voice phase accumulator. One voice per enabled cycle,
// chosen round-robin, advances phase += inc through a CHUNK-bit carry pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : issue the next voice this cycle
//   inc_we/addr/data    : increment register write
//   clr_we/addr         : zero a voice phase (note-on)
//   phase_out/voice_out : updated phase and its voice
//   wrap_out            : carry out of the top chunk
//   valid_out           : outputs carry a retired voice this cycle
module pipelined_phase_accumulator
    import synth_pkg::*;
#(
    parameter int unsigned WIDTH  = PHASE_WIDTH,
    parameter int unsigned CHUNK  = CHUNK_WIDTH,
    parameter int unsigned VOICES = NUM_VOICES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      inc_we,
    input  logic [$clog2(VOICES)-1:0] inc_addr,
    input  logic [WIDTH-1:0]          inc_data,
    input  logic                      clr_we,
    input  logic [$clog2(VOICES)-1:0] clr_addr,
    output logic [WIDTH-1:0]          phase_out,
    output logic [$clog2(VOICES)-1:0] voice_out,
    output logic                      wrap_out,
    output logic                      valid_out
);

    localparam int unsigned NSTAGES = WIDTH / CHUNK;
    localparam int unsigned AW      = $clog2(VOICES);

    typedef logic [AW-1:0] vidx_t;

    // st[k] travels alongside adder k: acc holds result chunks 0..k-1,
    // opnd_a/opnd_b hold the operands still to be added by later slices.
    typedef struct packed {
        logic             valid;
        logic             kill;
        vidx_t            voice;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] opnd_a;
        logic [WIDTH-1:0] opnd_b;
    } pipe_t;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("WIDTH must be a multiple of CHUNK");
    end
    if (VOICES < NSTAGES) begin : g_bad_voices
        $error("VOICES must be at least WIDTH/CHUNK");
    end

    logic [WIDTH-1:0] phase_mem [VOICES];
    logic [WIDTH-1:0] inc_mem   [VOICES];
    vidx_t            ptr;
    pipe_t            st        [NSTAGES];
    pipe_t            issue;
    logic [CHUNK-1:0] sum       [NSTAGES];
    logic             carry     [NSTAGES];
    logic [WIDTH-1:0] rd_phase;
    logic [WIDTH-1:0] result;
    logic             wb_en;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            chunk_adder_stage #(.CHUNK(CHUNK)) u_add (
                .clk   (clk),
                .rst_n (rst_n),
                .a     (rd_phase[0 +: CHUNK]),
                .b     (issue.opnd_b[0 +: CHUNK]),
                .c_in  (1'b0),
                .sum   (sum[k]),
                .c_out (carry[k])
            );
        end else begin : g_rest
            chunk_adder_stage #(.CHUNK(CHUNK)) u_add (
                .clk   (clk),
                .rst_n (rst_n),
                .a     (st[k-1].opnd_a[k*CHUNK +: CHUNK]),
                .b     (st[k-1].opnd_b[k*CHUNK +: CHUNK]),
                .c_in  (carry[k-1]),
                .sum   (sum[k]),
                .c_out (carry[k])
            );
        end
    end

    always_comb begin
        result = st[NSTAGES-1].acc;
        result[(NSTAGES-1)*CHUNK +: CHUNK] = sum[NSTAGES-1];
    end

    assign wb_en = st[NSTAGES-1].valid && !st[NSTAGES-1].kill;

    // The register file is written at the end of the retire cycle, so a voice
    // re-issued in that same cycle (VOICES == NSTAGES) takes the result directly.
    always_comb begin
        rd_phase = phase_mem[ptr];
        if (wb_en && st[NSTAGES-1].voice == ptr) begin
            rd_phase = result;
        end
        issue        = '0;
        issue.valid  = en;
        issue.kill   = en && clr_we && (clr_addr == ptr);
        issue.voice  = ptr;
        issue.opnd_a = rd_phase;
        issue.opnd_b = inc_mem[ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                st[k] <= '0;
            end
        end else begin
            if (en) begin
                ptr <= (ptr == vidx_t'(VOICES - 1)) ? '0 : ptr + 1'b1;
            end
            st[0] <= issue;
            for (int unsigned k = 1; k < NSTAGES; k++) begin
                st[k]      <= st[k-1];
                st[k].kill <= st[k-1].kill || (clr_we && (clr_addr == st[k-1].voice));
                st[k].acc[(k-1)*CHUNK +: CHUNK] <= sum[k-1];
            end
        end
    end

    // Clear is applied after writeback so it wins on the same voice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                phase_mem[v] <= '0;
                inc_mem[v]   <= '0;
            end
        end else begin
            for (int unsigned v = 0; v < VOICES; v++) begin
                if (wb_en && st[NSTAGES-1].voice == vidx_t'(v)) begin
                    phase_mem[v] <= result;
                end
                if (clr_we && clr_addr == vidx_t'(v)) begin
                    phase_mem[v] <= '0;
                end
                if (inc_we && inc_addr == vidx_t'(v)) begin
                    inc_mem[v] <= inc_data;
                end
            end
        end
    end

    assign phase_out = result;
    assign voice_out = st[NSTAGES-1].voice;
    assign wrap_out  = carry[NSTAGES-1];
    assign valid_out = st[NSTAGES-1].valid;

endmodule

// File: tb/tb_pipelined_phase_accumulator.sv
module tb_pipelined_phase_accumulator;

    localparam int unsigned NST = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        inc_we;
    logic [2:0]  inc_addr;
    logic [31:0] inc_data;
    logic        clr_we;
    logic [2:0]  clr_addr;
    logic [31:0] phase_out;
    logic [2:0]  voice_out;
    logic        wrap_out;
    logic        valid_out;

    pipelined_phase_accumulator #(
        .WIDTH  (32),
        .CHUNK  (8),
        .VOICES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .inc_we    (inc_we),
        .inc_addr  (inc_addr),
        .inc_data  (inc_data),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .phase_out (phase_out),
        .voice_out (voice_out),
        .wrap_out  (wrap_out),
        .valid_out (valid_out)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] phase;
        logic [2:0]  voice;
        logic        wrap;
    } exp_t;

    exp_t        q[$];
    int unsigned checks   = 0;
    int unsigned errors   = 0;
    int unsigned edge_cnt = 0;
    logic [31:0] phase_m [8];
    logic [31:0] inc_m   [8];
    logic [2:0]  ptr_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            phase_m[i] = '0;
            inc_m[i]   = '0;
        end
        ptr_m = '0;
    endtask

    // Drive one cycle of stimulus and update the architectural model:
    // the issue reads old phase/inc, then the inc write and clear land.
    task automatic step(input logic e, input logic iwe = 1'b0, input logic [2:0] ia = 3'd0,
                        input logic [31:0] id = 32'd0, input logic cwe = 1'b0,
                        input logic [2:0] ca = 3'd0);
        logic [32:0] s;
        @(negedge clk);
        en       = e;
        inc_we   = iwe;
        inc_addr = ia;
        inc_data = id;
        clr_we   = cwe;
        clr_addr = ca;
        if (e) begin
            s = {1'b0, phase_m[ptr_m]} + {1'b0, inc_m[ptr_m]};
            q.push_back('{due: edge_cnt + NST, phase: s[31:0], voice: ptr_m, wrap: s[32]});
            phase_m[ptr_m] = s[31:0];
            ptr_m = ptr_m + 3'd1;
        end
        if (iwe) inc_m[ia] = id;
        if (cwe) phase_m[ca] = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        #1;
        if (!rst_n) begin
            chk("valid_in_reset", 32'(valid_out), 32'd0);
        end else if (q.size() > 0 && q[0].due == edge_cnt) begin
            e = q.pop_front();
            chk("valid_out", 32'(valid_out), 32'd1);
            chk("phase_out", phase_out, e.phase);
            chk("voice_out", 32'(voice_out), 32'(e.voice));
            chk("wrap_out", 32'(wrap_out), 32'(e.wrap));
        end else begin
            chk("idle_valid", 32'(valid_out), 32'd0);
        end
    end

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        inc_we   = 1'b0;
        inc_addr = '0;
        inc_data = '0;
        clr_we   = 1'b0;
        clr_addr = '0;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", phase_out, 32'd0);
        chk("rst_voice", 32'(voice_out), 32'd0);
        chk("rst_wrap", 32'(wrap_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        rst_n = 1'b1;

        // all increments zero: phase 0, voices cycling
        run(12);

        // carry across chunks on voice 0: FF01 then +FF -> 0001_0000
        step(1'b0, 1'b1, 3'd0, 32'h0000_FF01);
        while (ptr_m != 3'd0) step(1'b1);
        run(8);
        step(1'b0, 1'b1, 3'd0, 32'h0000_00FF);
        run(8);

        // wrap on voice 3 (inc write and clear together), other voices busy too
        step(1'b0, 1'b1, 3'd3, 32'h8000_0000, 1'b1, 3'd3);
        step(1'b0, 1'b1, 3'd5, 32'h0123_4567);
        step(1'b0, 1'b1, 3'd6, 32'hFFFF_FFFF);
        run(16);

        // increment write landing on the issue of that voice uses the old value
        step(1'b1, 1'b1, ptr_m, 32'h0000_0010);
        run(8);

        // bubbles
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        step(1'b0); step(1'b1); step(1'b1); step(1'b0);

        // clear voice 2 while it sits in stage 2
        step(1'b0, 1'b1, 3'd2, 32'd5);
        while (ptr_m != 3'd2) step(1'b1);
        run(3);
        step(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 3'd2);
        run(8);

        // clear on the same cycle voice 5 issues
        while (ptr_m != 3'd5) step(1'b1);
        step(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 3'd5);
        run(8);

        // async reset with all stages full
        run(6);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid_out), 32'd0);
        chk("async_rst_phase", phase_out, 32'd0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 3'd0, 32'h0000_1234);
        run(9);

        for (int i = 0; i < 8; i++) step(1'b0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
